imem_loader: RTL and testbench

//  Boot-time writer for the core's instruction memory. Takes a framed byte stream on a valid/ready port.

---
 rtl/core_pkg.sv | 19 +
 rtl/byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: instruction-memory address width (also the core pc
// width) and the boot loader FSM state encoding.
package core_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned LD_STATE_W  = 3;

  typedef enum logic [LD_STATE_W-1:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_WRITE,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clear       restart packing at byte 0 (new frame)
//   shift_en    accept din into the current byte lane
//   din         incoming byte
//   word        assembled word (byte k lands in bits [8k+7:8k])
//   byte_idx    lane the next byte will be written to
//   word_ready  one-cycle pulse the cycle after the 4th byte of a word
module byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_ready
);

  // Each word fully overwrites all four lanes, so no clear is needed between words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word       <= '0;
      byte_idx   <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        word     <= '0;
        byte_idx <= '0;
      end else if (shift_en) begin
        word[{byte_idx, 3'b000} +: 8] <= din;
        byte_idx   <= byte_idx + 2'd1;
        word_ready <= (byte_idx == 2'd3);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives a framed byte stream
// (LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum), writes little-endian
// words to consecutive addresses from 0 and keeps the core in reset until a
// complete, checksum-valid image has been loaded.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid, in_data    byte stream input
//   in_ready             byte accepted when in_valid & in_ready
//   imem_we              one-cycle write strobe per word
//   imem_addr            word address of the write
//   imem_wdata           instruction word
//   core_rstn            core reset, high only in DONE
//   done, error          load result levels
module imem_loader
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = 16;

  ld_state_t        state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] word_cnt;
  logic [7:0]       csum;

  logic             accept;
  logic             can_start;
  logic             pk_clear;
  logic             pk_shift;
  logic [1:0]       pk_idx;
  logic             pk_word_ready;
  logic [31:0]      pk_word;

  assign accept    = in_valid & in_ready;
  assign can_start = (state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR);
  assign pk_clear  = start & can_start;
  assign pk_shift  = accept & (state == LD_DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (pk_clear),
    .shift_en   (pk_shift),
    .din        (in_data),
    .word       (pk_word),
    .byte_idx   (pk_idx),
    .word_ready (pk_word_ready)
  );

  // The packer's word_ready pulse lines up with the WRITE state cycle; the
  // address is the not-yet-incremented word counter (N <= DEPTH, so no wrap).
  assign imem_we    = pk_word_ready;
  assign imem_wdata = pk_word;
  assign imem_addr  = word_cnt[ADDR_W-1:0];

  // Load FSM; outputs are updated together with each state transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LD_IDLE;
      in_ready  <= 1'b0;
      core_rstn <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      word_cnt  <= '0;
      csum      <= '0;
    end else begin
      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state     <= LD_LEN_LO;
            in_ready  <= 1'b1;
            core_rstn <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            len       <= '0;
            word_cnt  <= '0;
            csum      <= '0;
          end
        end
        LD_LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            state    <= LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            if ({in_data, len[7:0]} == 16'd0) begin
              state <= LD_CSUM;
            end else if (17'({in_data, len[7:0]}) > 17'(DEPTH)) begin
              state    <= LD_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            if (pk_idx == 2'd3) begin
              state    <= LD_WRITE;
              in_ready <= 1'b0;
            end
          end
        end
        LD_WRITE: begin
          word_cnt <= word_cnt + 16'd1;
          in_ready <= 1'b1;
          if ((word_cnt + 16'd1) == len) begin
            state <= LD_CSUM;
          end else begin
            state <= LD_DATA;
          end
        end
        LD_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= LD_DONE;
              done      <= 1'b1;
              core_rstn <= 1'b1;
            end else begin
              state <= LD_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= LD_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are driven byte by byte,
// expected memory writes are queued as payload is sent and compared by a
// write monitor as the loader emits them.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rstn;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  wr_t         mon_exp;
  wr_t         mon_got;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_cnt++;
      mon_got = {imem_addr, imem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mon_got.addr, mon_got.data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns on the falling edge after its transfer.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    t = 0;
    if (gaps) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
    end
    @(negedge clk);
  endtask

  // Sends a full frame from frame_words[0..n-1], queueing the expected writes.
  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [15:0] len;
    logic [7:0]  cs;
    logic [31:0] w;
    len = 16'(n);
    cs  = 8'h00;
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      exp_q.push_back({ADDR_W'(i), w});
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], gaps);
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b expected 0", imem_we); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_imem_addr: got %0d expected 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata: got %h expected 0", imem_wdata); end
    checks++; if ({core_rstn, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: got core_rstn/done/error=%b expected 000", {core_rstn, done, error}); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
  endtask

  task automatic test_basic();
    int we0;
    frame_words = '{32'h00500013, 32'h00100093};
    we0 = we_cnt;
    pulse_start();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", in_ready); end
    send_frame(2, 1'b0, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL basic_status: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    checks++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL basic_we_count: got %0d expected 2", we_cnt - we0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    int we0;
    frame_words = '{32'h00500013, 32'h00100093};
    we0 = we_cnt;
    pulse_start();
    checks++; if ({done, core_rstn} !== 2'b00) begin errors++; $display("FAIL restart_drop: got done/core_rstn=%b expected 00", {done, core_rstn}); end
    send_frame(2, 1'b0, 1'b1);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL gaps_status: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    checks++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL gaps_we_count: got %0d expected 2", we_cnt - we0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL gaps_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_len_overflow();
    int we0;
    we0 = we_cnt;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    in_valid = 1'b0;
    checks++; if ({done, error, core_rstn} !== 3'b010) begin errors++; $display("FAIL ovf_status: got done/error/core_rstn=%b expected 010", {done, error, core_rstn}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b expected 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL ovf_we_count: got %0d expected 0", we_cnt - we0); end
  endtask

  task automatic test_bad_csum();
    int we0;
    frame_words = '{32'h00500013, 32'h00100093};
    we0 = we_cnt;
    pulse_start();
    send_frame(2, 1'b1, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b010) begin errors++; $display("FAIL badcs_status: got done/error/core_rstn=%b expected 010", {done, error, core_rstn}); end
    checks++; if (we_cnt - we0 !== 2) begin errors++; $display("FAIL badcs_we_count: got %0d expected 2", we_cnt - we0); end
    pulse_start();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL badcs_err_clear: got %b expected 0", error); end
    send_frame(2, 1'b0, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL badcs_recover: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
  endtask

  task automatic test_zero_len();
    int we0;
    frame_words.delete();
    we0 = we_cnt;
    pulse_start();
    send_frame(0, 1'b0, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL zero_status: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    pulse_start();
    send_frame(0, 1'b1, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b010) begin errors++; $display("FAIL zero_bad_status: got done/error/core_rstn=%b expected 010", {done, error, core_rstn}); end
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL zero_we_count: got %0d expected 0", we_cnt - we0); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    w = 32'hA5C30F1E;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({ADDR_W'(0), w});
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    in_valid = 1'b0;
    pulse_start();
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
    send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], 1'b0);
    in_valid = 1'b0;
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL ignore_status: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ignore_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_rst_mid_load();
    int we0;
    we0 = we_cnt;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if ({in_ready, imem_we, core_rstn, done, error} !== 5'b00000) begin errors++; $display("FAIL midrst_outputs: got ready/we/core_rstn/done/error=%b expected 00000", {in_ready, imem_we, core_rstn, done, error}); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL midrst_we_count: got %0d expected 0", we_cnt - we0); end
    frame_words = '{32'h00500013, 32'h00100093};
    pulse_start();
    send_frame(2, 1'b0, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL midrst_recover: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_max_depth();
    int we0;
    frame_words.delete();
    for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back($urandom());
    we0 = we_cnt;
    pulse_start();
    send_frame(int'(DEPTH), 1'b0, 1'b0);
    checks++; if ({done, error, core_rstn} !== 3'b101) begin errors++; $display("FAIL depth_status: got done/error/core_rstn=%b expected 101", {done, error, core_rstn}); end
    checks++; if (we_cnt - we0 !== int'(DEPTH)) begin errors++; $display("FAIL depth_we_count: got %0d expected %0d", we_cnt - we0, DEPTH); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL depth_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_len_overflow();
    test_bad_csum();
    test_zero_len();
    test_start_ignored();
    test_rst_mid_load();
    test_max_depth();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
